id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register and operand-resolution stage; consumes register-file read data.
//  - Captures decoded fields plus rs/rt values at the end of ID.
//  - Resolves data hazards: WB write-through bypass at capture, EX/MEM and MEM/WB forwarding

---
 rtl/mips_pkg.sv | 15 +
 rtl/operand_forward_mux.sv | 42 ++++
 rtl/id_ex_operand_stage.sv | 148 ++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared datapath defaults and forwarding-source encodings for the ID/EX stage.
package mips_pkg;

  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int DEFAULT_CTRL_W     = 12;

  // Operand source chosen by the EX forwarding muxes.
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/operand_forward_mux.sv
// Per-operand EX forwarding: MEM result beats WB data beats the registered value.
// Specifier $0 always yields zero and never takes a forwarded value.
module operand_forward_mux
  import mips_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] i_spec,
  input  logic [DATA_W-1:0]     i_reg_val,
  input  logic                  i_mem_regwrite,
  input  logic [REG_ADDR_W-1:0] i_mem_dst,
  input  logic [DATA_W-1:0]     i_mem_result,
  input  logic                  i_wb_regwrite,
  input  logic [REG_ADDR_W-1:0] i_wb_dst,
  input  logic [DATA_W-1:0]     i_wb_data,
  output logic [DATA_W-1:0]     o_operand,
  output logic [1:0]            o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_regwrite && (i_mem_dst != '0) && (i_mem_dst == i_spec);
  assign w_wb_hit  = i_wb_regwrite  && (i_wb_dst  != '0) && (i_wb_dst  == i_spec);

  // Pick the youngest producer of the operand; $0 is hard-wired to zero.
  always_comb begin
    o_operand = i_reg_val;
    o_sel     = FWD_REG;
    if (i_spec == '0) begin
      o_operand = '0;
    end else if (w_mem_hit) begin
      o_operand = i_mem_result;
      o_sel     = FWD_MEM;
    end else if (w_wb_hit) begin
      o_operand = i_wb_data;
      o_sel     = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with WB write-through capture, load-use stall detection
// and MEM/WB operand forwarding into EX.
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int CTRL_W     = DEFAULT_CTRL_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rs,
  input  logic                  i_id_uses_rt,
  input  logic [REG_ADDR_W-1:0] i_id_dst,
  input  logic                  i_id_regwrite,
  input  logic                  i_id_memread,
  input  logic [DATA_W-1:0]     i_id_imm,
  input  logic [CTRL_W-1:0]     i_id_ctrl,
  input  logic [DATA_W-1:0]     i_rf_data1,
  input  logic [DATA_W-1:0]     i_rf_data2,
  input  logic                  i_mem_regwrite,
  input  logic [REG_ADDR_W-1:0] i_mem_dst,
  input  logic [DATA_W-1:0]     i_mem_result,
  input  logic                  i_wb_regwrite,
  input  logic [REG_ADDR_W-1:0] i_wb_dst,
  input  logic [DATA_W-1:0]     i_wb_data,
  output logic                  o_stall,
  output logic                  o_ex_valid,
  output logic [REG_ADDR_W-1:0] o_ex_rs,
  output logic [REG_ADDR_W-1:0] o_ex_rt,
  output logic [REG_ADDR_W-1:0] o_ex_dst,
  output logic                  o_ex_regwrite,
  output logic                  o_ex_memread,
  output logic [DATA_W-1:0]     o_ex_imm,
  output logic [CTRL_W-1:0]     o_ex_ctrl,
  output logic [DATA_W-1:0]     o_ex_op_a,
  output logic [DATA_W-1:0]     o_ex_op_b,
  output logic [1:0]            o_fwd_a_sel,
  output logic [1:0]            o_fwd_b_sel
);

  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_rs;
  logic [REG_ADDR_W-1:0] r_rt;
  logic [REG_ADDR_W-1:0] r_dst;
  logic                  r_regwrite;
  logic                  r_memread;
  logic [DATA_W-1:0]     r_imm;
  logic [CTRL_W-1:0]     r_ctrl;
  logic [DATA_W-1:0]     r_rs_val;
  logic [DATA_W-1:0]     r_rt_val;

  logic                  w_stall;
  logic                  w_wt_rs;
  logic                  w_wt_rt;
  logic [DATA_W-1:0]     w_rs_val;
  logic [DATA_W-1:0]     w_rt_val;

  // A load in EX cannot supply its data until MEM, so a dependent ID instruction
  // waits one cycle. A flushed ID instruction is dead and must not stall anything.
  assign w_stall = i_id_valid && !i_flush && r_valid && r_memread && (r_dst != '0) &&
                   ((i_id_uses_rs && (i_id_rs == r_dst)) ||
                    (i_id_uses_rt && (i_id_rt == r_dst)));

  // The RF write lands on the same edge we capture, so take WB data directly.
  assign w_wt_rs  = i_wb_regwrite && (i_wb_dst != '0) && (i_wb_dst == i_id_rs);
  assign w_wt_rt  = i_wb_regwrite && (i_wb_dst != '0) && (i_wb_dst == i_id_rt);
  assign w_rs_val = w_wt_rs ? i_wb_data : i_rf_data1;
  assign w_rt_val = w_wt_rt ? i_wb_data : i_rf_data2;

  // ID/EX register: reset clears everything, flush/stall insert a bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid    <= 1'b0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_dst      <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_imm      <= '0;
      r_ctrl     <= '0;
      r_rs_val   <= '0;
      r_rt_val   <= '0;
    end else if (i_flush || w_stall) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
    end else begin
      r_valid    <= i_id_valid;
      r_rs       <= i_id_rs;
      r_rt       <= i_id_rt;
      r_dst      <= i_id_dst;
      r_regwrite <= i_id_regwrite;
      r_memread  <= i_id_memread;
      r_imm      <= i_id_imm;
      r_ctrl     <= i_id_ctrl;
      r_rs_val   <= w_rs_val;
      r_rt_val   <= w_rt_val;
    end
  end

  operand_forward_mux #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_a (
    .i_spec         (r_rs),
    .i_reg_val      (r_rs_val),
    .i_mem_regwrite (i_mem_regwrite),
    .i_mem_dst      (i_mem_dst),
    .i_mem_result   (i_mem_result),
    .i_wb_regwrite  (i_wb_regwrite),
    .i_wb_dst       (i_wb_dst),
    .i_wb_data      (i_wb_data),
    .o_operand      (o_ex_op_a),
    .o_sel          (o_fwd_a_sel)
  );

  operand_forward_mux #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_b (
    .i_spec         (r_rt),
    .i_reg_val      (r_rt_val),
    .i_mem_regwrite (i_mem_regwrite),
    .i_mem_dst      (i_mem_dst),
    .i_mem_result   (i_mem_result),
    .i_wb_regwrite  (i_wb_regwrite),
    .i_wb_dst       (i_wb_dst),
    .i_wb_data      (i_wb_data),
    .o_operand      (o_ex_op_b),
    .o_sel          (o_fwd_b_sel)
  );

  assign o_stall       = w_stall;
  assign o_ex_valid    = r_valid;
  assign o_ex_rs       = r_rs;
  assign o_ex_rt       = r_rt;
  assign o_ex_dst      = r_dst;
  assign o_ex_regwrite = r_regwrite & r_valid;
  assign o_ex_memread  = r_memread & r_valid;
  assign o_ex_imm      = r_imm;
  assign o_ex_ctrl     = r_ctrl;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, forwarding priority, load-use stall,
// write-through capture, $0 handling and flush-over-stall.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        id_uses_rs, id_uses_rt;
  logic        id_regwrite, id_memread;
  logic [31:0] id_imm;
  logic [11:0] id_ctrl;
  logic [31:0] rf_data1, rf_data2;
  logic        mem_regwrite;
  logic [4:0]  mem_dst;
  logic [31:0] mem_result;
  logic        wb_regwrite;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;

  logic        stall, ex_valid, ex_regwrite, ex_memread;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic [31:0] ex_imm, ex_op_a, ex_op_b;
  logic [11:0] ex_ctrl;
  logic [1:0]  fwd_a_sel, fwd_b_sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_flush        (flush),
    .i_id_valid     (id_valid),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_id_uses_rs   (id_uses_rs),
    .i_id_uses_rt   (id_uses_rt),
    .i_id_dst       (id_dst),
    .i_id_regwrite  (id_regwrite),
    .i_id_memread   (id_memread),
    .i_id_imm       (id_imm),
    .i_id_ctrl      (id_ctrl),
    .i_rf_data1     (rf_data1),
    .i_rf_data2     (rf_data2),
    .i_mem_regwrite (mem_regwrite),
    .i_mem_dst      (mem_dst),
    .i_mem_result   (mem_result),
    .i_wb_regwrite  (wb_regwrite),
    .i_wb_dst       (wb_dst),
    .i_wb_data      (wb_data),
    .o_stall        (stall),
    .o_ex_valid     (ex_valid),
    .o_ex_rs        (ex_rs),
    .o_ex_rt        (ex_rt),
    .o_ex_dst       (ex_dst),
    .o_ex_regwrite  (ex_regwrite),
    .o_ex_memread   (ex_memread),
    .o_ex_imm       (ex_imm),
    .o_ex_ctrl      (ex_ctrl),
    .o_ex_op_a      (ex_op_a),
    .o_ex_op_b      (ex_op_b),
    .o_fwd_a_sel    (fwd_a_sel),
    .o_fwd_b_sel    (fwd_b_sel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_fwd();
    mem_regwrite = 1'b0; mem_dst = 5'd0; mem_result = 32'h0;
    wb_regwrite  = 1'b0; wb_dst  = 5'd0; wb_data    = 32'h0;
  endtask

  task automatic load_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic [4:0] dst, input logic rw,
                         input logic mr, input logic [31:0] d1, input logic [31:0] d2);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dst = dst; id_regwrite = rw; id_memread = mr; rf_data1 = d1; rf_data2 = d2;
  endtask

  initial begin
    // Reset with a live instruction presented in ID.
    rst = 1'b1; flush = 1'b0;
    idle_fwd();
    load_id(5'd3, 5'd4, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 32'h33, 32'h44);
    id_imm = 32'h1234; id_ctrl = 12'hABC;
    tick(); tick();
    check("rst_ex_valid",    32'(ex_valid),    32'd0);
    check("rst_ex_regwrite", 32'(ex_regwrite), 32'd0);
    check("rst_ex_memread",  32'(ex_memread),  32'd0);
    check("rst_stall",       32'(stall),       32'd0);
    check("rst_ex_rs",       32'(ex_rs),       32'd0);
    check("rst_ex_dst",      32'(ex_dst),      32'd0);
    check("rst_ex_imm",      ex_imm,           32'd0);
    check("rst_ex_ctrl",     32'(ex_ctrl),     32'd0);
    check("rst_fwd_a_sel",   32'(fwd_a_sel),   32'd0);
    check("rst_op_b",        ex_op_b,          32'd0);
    $display("txn reset: ex_valid=%0d stall=%0d", ex_valid, stall);

    // Forwarding priority on rs=$3: MEM over WB over register.
    rst = 1'b0;
    load_id(5'd3, 5'd4, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 32'h33, 32'h44);
    tick();
    id_valid = 1'b0;
    mem_regwrite = 1'b1; mem_dst = 5'd3; mem_result = 32'h11;
    wb_regwrite  = 1'b1; wb_dst  = 5'd3; wb_data    = 32'h22;
    #1;
    check("cap_ex_valid",    32'(ex_valid),    32'd1);
    check("cap_ex_imm",      ex_imm,           32'h1234);
    check("cap_ex_ctrl",     32'(ex_ctrl),     32'hABC);
    check("cap_ex_dst",      32'(ex_dst),      32'd8);
    check("cap_ex_regwrite", 32'(ex_regwrite), 32'd1);
    check("fwd_mem_op_a",    ex_op_a,          32'h11);
    check("fwd_mem_sel_a",   32'(fwd_a_sel),   32'd1);
    check("fwd_reg_op_b",    ex_op_b,          32'h44);
    check("fwd_reg_sel_b",   32'(fwd_b_sel),   32'd0);
    $display("txn fwd mem: op_a=0x%0h sel_a=%0d", ex_op_a, fwd_a_sel);
    mem_regwrite = 1'b0;
    #1;
    check("fwd_wb_op_a",  ex_op_a,         32'h22);
    check("fwd_wb_sel_a", 32'(fwd_a_sel),  32'd2);
    wb_regwrite = 1'b0;
    #1;
    check("fwd_none_op_a",  ex_op_a,        32'h33);
    check("fwd_none_sel_a", 32'(fwd_a_sel), 32'd0);
    $display("txn fwd wb/reg: op_a=0x%0h sel_a=%0d", ex_op_a, fwd_a_sel);

    // Load-use: lw $5 enters EX, dependent add (rt=$5) waits one cycle.
    idle_fwd();
    load_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 32'h100, 32'h0);
    tick();
    load_id(5'd2, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 32'h200, 32'h0);
    #1;
    check("lu_ex_memread", 32'(ex_memread), 32'd1);
    check("lu_stall",      32'(stall),      32'd1);
    tick();
    check("lu_bubble_valid",    32'(ex_valid),    32'd0);
    check("lu_bubble_regwrite", 32'(ex_regwrite), 32'd0);
    check("lu_bubble_memread",  32'(ex_memread),  32'd0);
    check("lu_stall_drop",      32'(stall),       32'd0);
    mem_regwrite = 1'b1; mem_dst = 5'd5; mem_result = 32'hBAD;
    tick();
    idle_fwd();
    id_valid = 1'b0;
    wb_regwrite = 1'b1; wb_dst = 5'd5; wb_data = 32'h55;
    #1;
    check("lu_ex_valid", 32'(ex_valid),   32'd1);
    check("lu_op_b",     ex_op_b,         32'h55);
    check("lu_sel_b",    32'(fwd_b_sel),  32'd2);
    check("lu_op_a",     ex_op_a,         32'h200);
    $display("txn load-use: op_b=0x%0h sel_b=%0d", ex_op_b, fwd_b_sel);

    // Write-through: WB writes $7 on the edge that captures a reader of $7.
    idle_fwd();
    load_id(5'd7, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 32'h0, 32'h0);
    wb_regwrite = 1'b1; wb_dst = 5'd7; wb_data = 32'hDEAD;
    tick();
    idle_fwd();
    id_valid = 1'b0;
    #1;
    check("wt_op_a",  ex_op_a,        32'hDEAD);
    check("wt_sel_a", 32'(fwd_a_sel), 32'd0);
    $display("txn write-through: op_a=0x%0h sel_a=%0d", ex_op_a, fwd_a_sel);

    // $0 is never forwarded or bypassed.
    load_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 32'h0, 32'h0);
    wb_regwrite = 1'b1; wb_dst = 5'd0; wb_data = 32'hFFFF;
    tick();
    id_valid = 1'b0;
    mem_regwrite = 1'b1; mem_dst = 5'd0; mem_result = 32'hFFFF;
    #1;
    check("zero_op_a",  ex_op_a,        32'h0);
    check("zero_sel_a", 32'(fwd_a_sel), 32'd0);
    check("zero_op_b",  ex_op_b,        32'h0);
    $display("txn reg0: op_a=0x%0h sel_a=%0d", ex_op_a, fwd_a_sel);

    // Flush in the same cycle as a load-use hazard: flush wins.
    idle_fwd();
    load_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 32'h1, 32'h0);
    tick();
    load_id(5'd9, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 32'h0, 32'h2);
    #1;
    check("fl_stall_noflush", 32'(stall), 32'd1);
    flush = 1'b1;
    #1;
    check("fl_stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b0;
    id_valid = 1'b0;
    #1;
    check("fl_ex_valid",    32'(ex_valid),    32'd0);
    check("fl_ex_regwrite", 32'(ex_regwrite), 32'd0);
    check("fl_ex_memread",  32'(ex_memread),  32'd0);
    $display("txn flush: ex_valid=%0d stall=%0d", ex_valid, stall);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
